// File: rtl/i2c_codec_pkg.sv
// Shared types and constants for the I2C codec register target.
// Holds the FSM state encoding, the codec address bytes and the bit counter width.
package i2c_codec_pkg;

  localparam logic [7:0] ADDR_BYTE_WR = 8'h34;
  localparam logic [7:0] ADDR_BYTE_RD = 8'h35;
  localparam int         BIT_CNT_W    = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_BYTE1,
    ST_ACK1,
    ST_BYTE2,
    ST_ACK2,
`ifdef I2C_CODEC_TARGET_READ_EN
    ST_RD_BYTE,
    ST_RD_ACK,
`endif
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_codec_target_filter.sv
// i2c_line_filter: 2-flop synchronizer plus FILT_LEN-sample stability filter, presets high.
// Latency 2 + FILT_LEN cycles from pin to level; rise/fall pulse in the cycle the level changes.
module i2c_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic CLOCK_50,
  input  logic iRST_N,
  input  logic line_in,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count restarts whenever the synchronized sample agrees with the current level.
  always_comb begin
    lvl_d  = lvl_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        lvl_d  = s2_q;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= line_in;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_codec_target.sv
// I2C target decoding 24-bit codec writes into one-cycle register strobes; read-back under I2C_CODEC_TARGET_READ_EN.
// oREG_WR one cycle after the filtered ACK2 SCL rise; no back-pressure, SCL is never stretched.
module i2c_codec_target
  import i2c_codec_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         FILT_LEN = 4,
  parameter int         SDA_HOLD = 8
) (
  input  logic       CLOCK_50,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       oREG_WR,
  output logic [6:0] oREG_ADDR,
  output logic [8:0] oREG_DATA,
  output logic       oBUSY
);

  localparam int HOLD_W = $clog2(SDA_HOLD + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_evt, stop_evt;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .CLOCK_50 (CLOCK_50),
    .iRST_N   (iRST_N),
    .line_in  (I2C_SCLK),
    .level_o  (scl_lvl),
    .rise_o   (scl_rise),
    .fall_o   (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .CLOCK_50 (CLOCK_50),
    .iRST_N   (iRST_N),
    .line_in  (I2C_SDAT),
    .level_o  (sda_lvl),
    .rise_o   (sda_rise),
    .fall_o   (sda_fall)
  );

  assign start_evt = sda_fall & scl_lvl;
  assign stop_evt  = sda_rise & scl_lvl;

  state_t                state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [6:0]            reg_q, reg_d;
  logic                  d8_q, d8_d;
  logic                  wr_q, wr_d;
  logic [6:0]            addr_q, addr_d;
  logic [8:0]            data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  pend_q, pend_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  oe_q, oe_d;
  logic [7:0]            shift_in;
  logic                  last_bit;
  logic                  addr_ok;
  logic                  drive_want;

  assign shift_in = {shift_q[6:0], sda_lvl};
  assign last_bit = (bit_cnt_q == BIT_CNT_W'(7));

`ifdef I2C_CODEC_TARGET_READ_EN
  logic       rd_q, rd_d;
  logic [7:0] tx_q, tx_d;
  logic       sel_q, sel_d;
  assign addr_ok = (shift_in[7:1] == DEV_ADDR);
`else
  assign addr_ok = (shift_in[7:1] == DEV_ADDR) && !shift_in[0];
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_d      = reg_q;
    d8_d       = d8_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    pend_d     = pend_q;
    hold_d     = hold_q;
    oe_d       = oe_q;
    drive_want = 1'b0;
`ifdef I2C_CODEC_TARGET_READ_EN
    rd_d       = rd_q;
    tx_d       = tx_q;
    sel_d      = sel_q;
`endif

    // SDA drive for the coming bit slot is decided by the state entered on the preceding rise.
    case (state_q)
      ST_ADDR_ACK, ST_ACK1, ST_ACK2: drive_want = 1'b1;
`ifdef I2C_CODEC_TARGET_READ_EN
      ST_RD_BYTE:                    drive_want = ~tx_q[7];
`endif
      default:                       drive_want = 1'b0;
    endcase

    if (start_evt || stop_evt) begin
      state_d   = start_evt ? ST_ADDR : ST_IDLE;
      busy_d    = start_evt;
      bit_cnt_d = '0;
      hold_d    = '0;
      pend_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      if (scl_rise) begin
        case (state_q)
          ST_ADDR, ST_BYTE1, ST_BYTE2: begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              bit_cnt_d = '0;
              if (state_q == ST_ADDR) begin
                state_d = addr_ok ? ST_ADDR_ACK : ST_IGNORE;
`ifdef I2C_CODEC_TARGET_READ_EN
                rd_d    = shift_in[0];
`endif
              end else if (state_q == ST_BYTE1) begin
                state_d = ST_ACK1;
                reg_d   = shift_in[7:1];
                d8_d    = shift_in[0];
              end else begin
                state_d = ST_ACK2;
              end
            end
          end
          ST_ADDR_ACK: begin
            state_d = ST_BYTE1;
`ifdef I2C_CODEC_TARGET_READ_EN
            if (rd_q) begin
              state_d = ST_RD_BYTE;
              tx_d    = {addr_q, data_q[8]};
              sel_d   = 1'b1;
            end
`endif
          end
          ST_ACK1: state_d = ST_BYTE2;
          ST_ACK2: begin
            state_d = ST_BYTE1;
            wr_d    = 1'b1;
            addr_d  = reg_q;
            data_d  = {d8_q, shift_q};
          end
`ifdef I2C_CODEC_TARGET_READ_EN
          ST_RD_BYTE: begin
            tx_d      = {tx_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              bit_cnt_d = '0;
              state_d   = ST_RD_ACK;
            end
          end
          ST_RD_ACK: begin
            if (sda_lvl) begin
              state_d = ST_IGNORE;
            end else begin
              state_d = ST_RD_BYTE;
              tx_d    = sel_q ? data_q[7:0] : {addr_q, data_q[8]};
              sel_d   = ~sel_q;
            end
          end
`endif
          default: ;
        endcase
      end

      if (scl_fall) begin
        pend_d = drive_want;
        hold_d = HOLD_W'(SDA_HOLD);
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
        if (hold_q == HOLD_W'(1)) oe_d = pend_q;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      reg_q     <= '0;
      d8_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
      hold_q    <= '0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      reg_q     <= reg_d;
      d8_q      <= d8_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      oe_q      <= oe_d;
    end
  end

`ifdef I2C_CODEC_TARGET_READ_EN
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      rd_q  <= 1'b0;
      tx_q  <= '0;
      sel_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      tx_q  <= tx_d;
      sel_q <= sel_d;
    end
  end
`endif

  assign I2C_SDAT  = oe_q ? 1'b0 : 1'bz;
  assign oREG_WR   = wr_q;
  assign oREG_ADDR = addr_q;
  assign oREG_DATA = data_q;
  assign oBUSY     = busy_q;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: bit-banged I2C initiator on an open-drain bus with pull-up.
module tb_i2c_codec_target;
  import i2c_codec_pkg::*;

  localparam int Q = 20;

  logic       CLOCK_50;
  logic       iRST_N;
  logic       scl;
  logic       m_sda_lo;
  wire        sda_bus;
  logic       oREG_WR;
  logic [6:0] oREG_ADDR;
  logic [8:0] oREG_DATA;
  logic       oBUSY;

  int n_cmp;
  int n_err;
  int wr_cnt;
  int wr_long;
  logic       wr_prev;
  logic [6:0] cap_addr [16];
  logic [8:0] cap_data [16];

  assign sda_bus = m_sda_lo ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_codec_target dut (
    .CLOCK_50  (CLOCK_50),
    .iRST_N    (iRST_N),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda_bus),
    .oREG_WR   (oREG_WR),
    .oREG_ADDR (oREG_ADDR),
    .oREG_DATA (oREG_DATA),
    .oBUSY     (oBUSY)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_prev <= 1'b0;
    end else begin
      if (oREG_WR) begin
        if (wr_prev) wr_long <= wr_long + 1;
        else if (wr_cnt < 16) begin
          cap_addr[wr_cnt] <= oREG_ADDR;
          cap_data[wr_cnt] <= oREG_DATA;
        end
        if (!wr_prev) wr_cnt <= wr_cnt + 1;
      end
      wr_prev <= oREG_WR;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge CLOCK_50);
  endtask

  task automatic i2c_start();
    m_sda_lo = 1'b0;
    scl      = 1'b1;
    qwait();
    m_sda_lo = 1'b1;
    qwait();
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    qwait();
    m_sda_lo = 1'b1;
    qwait();
    scl = 1'b1;
    qwait();
    m_sda_lo = 1'b0;
    qwait();
    qwait();
  endtask

  // One bit slot, starting just after SCL has gone low; optional short SCL low glitch mid-high.
  task automatic send_bit(input logic b, input logic glitch);
    qwait();
    m_sda_lo = ~b;
    qwait();
    scl = 1'b1;
    qwait();
    if (glitch) begin
      scl = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      scl = 1'b1;
    end
    qwait();
    scl = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    qwait();
    m_sda_lo = 1'b0;
    qwait();
    scl = 1'b1;
    qwait();
    b = sda_bus;
    qwait();
    scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] v, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i], i == glitch_bit);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic master_ack);
    logic b;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v = {v[6:0], b};
    end
    send_bit(~master_ack, 1'b0);
  endtask

  logic       ack;
  logic [7:0] rb;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    wr_cnt   = 0;
    wr_long  = 0;
    scl      = 1'b1;
    m_sda_lo = 1'b0;
    iRST_N   = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check_eq("rst_wr",   {31'd0, oREG_WR}, 32'd0);
    check_eq("rst_addr", {25'd0, oREG_ADDR}, 32'd0);
    check_eq("rst_data", {23'd0, oREG_DATA}, 32'd0);
    check_eq("rst_busy", {31'd0, oBUSY}, 32'd0);
    check_eq("rst_sda",  {31'd0, sda_bus}, 32'd1);
    iRST_N = 1'b1;
    qwait();

    // Single register write
    i2c_start();
    write_byte(ADDR_BYTE_WR, -1, ack); check_eq("t1_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h08, -1, ack);        check_eq("t1_ack_b1",   {31'd0, ack}, 32'd0);
    write_byte(8'h11, -1, ack);        check_eq("t1_ack_b2",   {31'd0, ack}, 32'd0);
    check_eq("t1_busy", {31'd0, oBUSY}, 32'd1);
    i2c_stop();
    check_eq("t1_cnt",  wr_cnt, 32'd1);
    check_eq("t1_addr", {25'd0, cap_addr[0]}, 32'h04);
    check_eq("t1_data", {23'd0, cap_data[0]}, 32'h011);
    check_eq("t1_idle", {31'd0, oBUSY}, 32'd0);

    // Two pairs in one transaction
    i2c_start();
    write_byte(ADDR_BYTE_WR, -1, ack); check_eq("t2_ack0", {31'd0, ack}, 32'd0);
    write_byte(8'h1E, -1, ack);        check_eq("t2_ack1", {31'd0, ack}, 32'd0);
    write_byte(8'h00, -1, ack);        check_eq("t2_ack2", {31'd0, ack}, 32'd0);
    write_byte(8'h12, -1, ack);        check_eq("t2_ack3", {31'd0, ack}, 32'd0);
    write_byte(8'h01, -1, ack);        check_eq("t2_ack4", {31'd0, ack}, 32'd0);
    i2c_stop();
    check_eq("t2_cnt",   wr_cnt, 32'd3);
    check_eq("t2_addr0", {25'd0, cap_addr[1]}, 32'h0F);
    check_eq("t2_data0", {23'd0, cap_data[1]}, 32'h000);
    check_eq("t2_addr1", {25'd0, cap_addr[2]}, 32'h09);
    check_eq("t2_data1", {23'd0, cap_data[2]}, 32'h001);

    // Foreign address: NACK throughout, no strobe
    i2c_start();
    write_byte(8'h40, -1, ack); check_eq("t3_nack_addr", {31'd0, ack}, 32'd1);
    write_byte(8'h08, -1, ack); check_eq("t3_nack_b1",   {31'd0, ack}, 32'd1);
    write_byte(8'h11, -1, ack); check_eq("t3_nack_b2",   {31'd0, ack}, 32'd1);
    i2c_stop();
    check_eq("t3_cnt", wr_cnt, 32'd3);

`ifndef I2C_CODEC_TARGET_READ_EN
    i2c_start();
    write_byte(ADDR_BYTE_RD, -1, ack); check_eq("rd_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check_eq("rd_cnt", wr_cnt, 32'd3);
`endif

    // Partial pair discarded by STOP, then full pair
    i2c_start();
    write_byte(ADDR_BYTE_WR, -1, ack);
    write_byte(8'h0E, -1, ack); check_eq("t4_ack_part", {31'd0, ack}, 32'd0);
    i2c_stop();
    check_eq("t4_cnt_part", wr_cnt, 32'd3);
    i2c_start();
    write_byte(ADDR_BYTE_WR, -1, ack);
    write_byte(8'h0E, -1, ack);
    write_byte(8'h4D, -1, ack);
    i2c_stop();
    check_eq("t4_cnt",  wr_cnt, 32'd4);
    check_eq("t4_addr", {25'd0, cap_addr[3]}, 32'h07);
    check_eq("t4_data", {23'd0, cap_data[3]}, 32'h04D);

    // Short SCL glitch inside BYTE2
    i2c_start();
    write_byte(ADDR_BYTE_WR, -1, ack);
    write_byte(8'h08, -1, ack);
    write_byte(8'h11, 3, ack); check_eq("t5_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    check_eq("t5_cnt",  wr_cnt, 32'd5);
    check_eq("t5_addr", {25'd0, cap_addr[4]}, 32'h04);
    check_eq("t5_data", {23'd0, cap_data[4]}, 32'h011);

    // Reset asserted while the target holds ACK1 low
    i2c_start();
    write_byte(ADDR_BYTE_WR, -1, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h0A >> i), 1'b0);
    qwait();
    m_sda_lo = 1'b0;
    qwait();
    scl = 1'b1;
    qwait();
    check_eq("t6_sda_low", {31'd0, sda_bus}, 32'd0);
    iRST_N = 1'b0;
    @(negedge CLOCK_50);
    check_eq("t6_sda_rel", {31'd0, sda_bus}, 32'd1);
    check_eq("t6_addr",    {25'd0, oREG_ADDR}, 32'd0);
    check_eq("t6_busy",    {31'd0, oBUSY}, 32'd0);
    iRST_N = 1'b1;
    qwait();
    scl = 1'b0;
    write_byte(8'h22, -1, ack); check_eq("t6_ign", {31'd0, ack}, 32'd1);
    i2c_stop();
    check_eq("t6_cnt", wr_cnt, 32'd5);

`ifdef I2C_CODEC_TARGET_READ_EN
    i2c_start();
    write_byte(ADDR_BYTE_WR, -1, ack);
    write_byte(8'h09, -1, ack);
    write_byte(8'h11, -1, ack);
    i2c_stop();
    check_eq("rd_wr_cnt",  wr_cnt, 32'd6);
    check_eq("rd_wr_data", {23'd0, cap_data[5]}, 32'h111);
    i2c_start();
    write_byte(ADDR_BYTE_RD, -1, ack); check_eq("rd_ack", {31'd0, ack}, 32'd0);
    read_byte(rb, 1'b1); check_eq("rd_byte0", {24'd0, rb}, 32'h09);
    read_byte(rb, 1'b0); check_eq("rd_byte1", {24'd0, rb}, 32'h11);
    i2c_stop();
    check_eq("rd_idle", {31'd0, oBUSY}, 32'd0);
`endif

    check_eq("wr_width", wr_long, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
